display_scan: RTL
=================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter PRESCALE, default 50000: clock cycles per digit slot; legal range DEADTIME+2 to 2^20.
REQ-002 Parameter DEADTIME, default 16: blanked cycles at the start of each slot; minimum 1.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port enable, input, 1: scanning runs while high.
REQ-006 Ports ones, tens, hundreds, thousands, input, 7 each: segment patterns; bit0=a … bit6=g; 1 = lit.
REQ-007 Port segments, output, 7: shared segment bus; 1 = lit.
REQ-008 Port anodes, output, 4: one-hot active-low digit select; bit0=ones … bit3=thousands.
REQ-009 Port frameStart, output, 1: one-cycle pulse when a new frame snapshot is taken.

Function
REQ-010 States SHALL be IDLE, BLANK and DRIVE; a slot counter runs 0..PRESCALE-1; a digit index runs 0..3 and wraps 3->0.
REQ-011 IDLE: anodes=4'b1111, segments=0; with enable high, the next edge SHALL enter BLANK with digit 0 and count 0, capture all four inputs into the snapshot, and pulse frameStart.
REQ-012 BLANK: anodes=4'b1111, segments=0; after DEADTIME cycles (count reaches DEADTIME) the block SHALL enter DRIVE.
REQ-013 DRIVE: anodes SHALL be low only on the current digit bit; segments SHALL equal that digit's snapshot value.
REQ-014 At count PRESCALE-1 the counter SHALL clear, the digit SHALL advance, and the state SHALL return to BLANK; the wrap 3->0 SHALL re-capture the snapshot and pulse frameStart.
REQ-015 All outputs SHALL be registered and SHALL change on the same edge as the state; frame period is exactly 4*PRESCALE cycles.
REQ-016 Input changes within a frame SHALL NOT affect outputs until the next snapshot (no tearing).
REQ-017 If enable is low at any edge, the next state SHALL be IDLE with count=0 and digit=0; enable wins over slot wrap in the same cycle.
REQ-018 If enable rises on the same edge that reset is released, the first frame SHALL start one cycle after release.

Reset
REQ-019 When reset is low at an edge: state=IDLE, count=0, digit=0, snapshot=0, anodes=4'b1111, segments=7'b0, frameStart=0.
REQ-020 Reset SHALL override enable and any in-progress slot, including mid-DRIVE.

Configuration
REQ-021 Macro DISPLAY_SCAN_LZB_EN, when defined, SHALL enable leading-zero blanking, evaluated on the snapshot:
- thousands blanked if equal to SEG_ZERO.
- hundreds blanked if thousands blanked and hundreds equals SEG_ZERO.
- tens likewise, conditioned on hundreds.
- ones never blanked.
- A blanked digit SHALL keep anodes=4'b1111 and segments=0 through its DRIVE slot; slot timing is unchanged.
REQ-022 Without DISPLAY_SCAN_LZB_EN, every digit SHALL be driven as captured, and no blanking logic SHALL be synthesized.

Structure
REQ-023 Package display_pkg SHALL hold:
- SEG_ZERO = 7'h3F
- SEG_BLANK = 7'h00
- NUM_DIGITS = 4
- ANODES_OFF = 4'b1111
- the scan-state enum
REQ-024 Sub-module scan_prescaler SHALL implement the slot counter (PRESCALE, DEADTIME) and emit deadDone and slotEnd strobes; display_scan SHALL hold the FSM, snapshot and output registers.

Verification (PRESCALE=8, DEADTIME=2 unless stated)
REQ-025 Reset: hold reset low 3 cycles with enable=1 -> anodes=1111, segments=0, frameStart=0 throughout.
REQ-026 Scan order: ones=7'h06, tens=7'h5B, hundreds=7'h4F, thousands=7'h66 -> anodes 1110/1101/1011/0111 each low for 6 cycles after 2 blank cycles, segments matching, frameStart every 32 cycles.
REQ-027 Tearing: change ones to 7'h7F during the tens slot -> 7'h06 still shown for ones in the current frame; 7'h7F shown only after the next frameStart.
REQ-028 Leading-zero blanking: all inputs 7'h3F -> with the macro only anode bit0 ever goes low; without the macro all four digits show 7'h3F. Also thousands=7'h3F, hundreds=7'h06 -> only thousands blanked.
REQ-029 Enable drop: deassert enable mid-DRIVE of hundreds -> next cycle anodes=1111, segments=0; reassert -> frameStart one cycle later, digit 0 blank for 2 cycles.
REQ-030 Reset mid-frame: assert reset during the tens DRIVE slot -> next edge gives all reset values; after release the first frame uses a fresh snapshot.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, scan-state enum and snapshot type for the multiplexed display scanner.
// The leading-zero helper is used only when DISPLAY_SCAN_LZB_EN is defined.
package display_pkg;

  localparam logic [6:0]  SEG_ZERO   = 7'h3F;
  localparam logic [6:0]  SEG_BLANK  = 7'h00;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  // Index 0 = ones ... index 3 = thousands.
  typedef logic [NUM_DIGITS-1:0][6:0] snap_t;

  // A digit is blanked only if every more-significant digit is also a blanked zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input snap_t s);
    logic [NUM_DIGITS-1:0] m;
    m    = '0;
    m[3] = (s[3] == SEG_ZERO);
    m[2] = m[3] && (s[2] == SEG_ZERO);
    m[1] = m[2] && (s[1] == SEG_ZERO);
    return m;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter for display_scan: counts 0..PRESCALE-1 while run is high, held at 0 otherwise.
// deadDone marks the last blanked cycle of a slot, slotEnd the last cycle of the slot.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DEADTIME = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic deadDone,
  output logic slotEnd
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST      = W'(PRESCALE - 1);
  localparam logic [W-1:0] DEAD_LAST = W'(DEADTIME - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign deadDone = run && (count == DEAD_LAST);
  assign slotEnd  = run && (count == LAST);

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame input snapshot and registered outputs.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DEADTIME = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] ones,
  input  logic [6:0] tens,
  input  logic [6:0] hundreds,
  input  logic [6:0] thousands,
  output logic [6:0] segments,
  output logic [3:0] anodes,
  output logic       frameStart
);

  scan_state_t state, state_n;
  logic [1:0]  digit, digit_n;
  snap_t       snap, snap_n;
  logic [3:0]  anodes_n;
  logic [6:0]  segments_n;
  logic        frame_n;
  logic        show;
  logic        run;
  logic        deadDone;
  logic        slotEnd;
`ifdef DISPLAY_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lzb;
`endif

  assign run = enable && (state != IDLE);

  scan_prescaler #(
    .PRESCALE(PRESCALE),
    .DEADTIME(DEADTIME)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .deadDone(deadDone),
    .slotEnd (slotEnd)
  );

  // Outputs are derived from the next state so they update on the same edge as the state.
  always_comb begin
    state_n    = state;
    digit_n    = digit;
    snap_n     = snap;
    frame_n    = 1'b0;
    anodes_n   = ANODES_OFF;
    segments_n = SEG_BLANK;

    if (!enable) begin
      state_n = IDLE;
      digit_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = BLANK;
          digit_n = '0;
          snap_n  = {thousands, hundreds, tens, ones};
          frame_n = 1'b1;
        end
        BLANK: begin
          if (deadDone) state_n = DRIVE;
        end
        DRIVE: begin
          if (slotEnd) begin
            state_n = BLANK;
            digit_n = digit + 2'd1;
            if (digit == 2'd3) begin
              snap_n  = {thousands, hundreds, tens, ones};
              frame_n = 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          digit_n = '0;
        end
      endcase
    end

    show = (state_n == DRIVE);
`ifdef DISPLAY_SCAN_LZB_EN
    lzb  = lz_mask(snap_n);
    show = show && !lzb[digit_n];
`endif
    if (show) begin
      anodes_n[digit_n] = 1'b0;
      segments_n        = snap_n[digit_n];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      digit      <= '0;
      snap       <= '0;
      anodes     <= ANODES_OFF;
      segments   <= SEG_BLANK;
      frameStart <= 1'b0;
    end else begin
      state      <= state_n;
      digit      <= digit_n;
      snap       <= snap_n;
      anodes     <= anodes_n;
      segments   <= segments_n;
      frameStart <= frame_n;
    end
  end

endmodule
